// File: rtl/entry_pkg.sv
// Shared definitions for the switch_entry operator-input front end.
//   state_t        : debounce FSM encoding
//   DEB_CYCLES_DEF : default debounce length in clki cycles (10 ms at 50 MHz)
//   BITCNT_W       : width of the committed-bit counter
package entry_pkg;

  localparam int DEB_CYCLES_DEF = 500000;
  localparam int BITCNT_W       = 4;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/switch_entry_sync2.sv
// sync2: two-flop synchronizer for an asynchronous level input.
//   clki : clock
//   rst  : synchronous active-low reset, clears both flops
//   d    : asynchronous input
//   q    : synchronized output (two clki edges of latency)
module sync2 (
  input  logic clki,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clki) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/switch_entry.sv
// switch_entry: debounces a pushbutton and commits the data switch as one
// serial bit per accepted press.
//   clki   : clock
//   rst    : synchronous active-low reset
//   btn    : raw pushbutton (1 = pressed), asynchronous and bouncing
//   sw     : raw data switch, asynchronous
//   x      : last committed bit
//   xv     : one-cycle strobe per accepted press
//   hist   : last HIST_W committed bits, newest in bit 0
//   bitcnt : number of committed bits, modulo 2**BITCNT_W
//
// state        | meaning
// RELEASED     | button idle, waiting for synchronized press
// PRESS_WAIT   | press seen, counting stable cycles before commit
// PRESSED      | press accepted, bit committed, waiting for release
// RELEASE_WAIT | release seen, counting stable cycles before idle
module switch_entry
  import entry_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int HIST_W     = 8
) (
  input  logic                clki,
  input  logic                rst,
  input  logic                btn,
  input  logic                sw,
  output logic                x,
  output logic                xv,
  output logic [HIST_W-1:0]   hist,
  output logic [BITCNT_W-1:0] bitcnt
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES - 1);

  logic             btn_s;
  logic             sw_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             commit;

  sync2 u_sync_btn (.clki(clki), .rst(rst), .d(btn), .q(btn_s));
  sync2 u_sync_sw  (.clki(clki), .rst(rst), .d(sw),  .q(sw_s));

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    commit    = 1'b0;
    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_clr   = 1'b1;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = RELEASED;
          cnt_clr   = 1'b1;
        end else if (cnt == CNT_TC) begin
          state_nxt = PRESSED;
          cnt_clr   = 1'b1;
          commit    = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_clr   = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // A return to high during release debounce is a bounce of a press
        // that was already committed, so it goes back to PRESSED silently.
        if (btn_s) begin
          state_nxt = PRESSED;
          cnt_clr   = 1'b1;
        end else if (cnt == CNT_TC) begin
          state_nxt = RELEASED;
          cnt_clr   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clki) begin
    if (!rst) begin
      state  <= RELEASED;
      cnt    <= '0;
      x      <= 1'b0;
      xv     <= 1'b0;
      hist   <= '0;
      bitcnt <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CNT_W'(1);
      end
      // commit is only true on the PRESS_WAIT->PRESSED edge, so xv can
      // never stay high for two cycles.
      xv <= commit;
      if (commit) begin
        x      <= sw_s;
        hist   <= {hist[HIST_W-2:0], sw_s};
        bitcnt <= bitcnt + BITCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_switch_entry.sv
module tb_switch_entry;
  import entry_pkg::*;

  localparam int DEB = 4;
  localparam int HW  = 8;
  localparam int LAT = DEB + 2;

  logic          clki;
  logic          rst;
  logic          btn;
  logic          sw;
  logic          x;
  logic          xv;
  logic [HW-1:0] hist;
  logic [3:0]    bitcnt;

  int n_checks = 0;
  int n_fail   = 0;
  int xv_count = 0;
  logic xv_prev = 1'b0;

  switch_entry #(.DEB_CYCLES(DEB), .HIST_W(HW)) dut (
    .clki(clki), .rst(rst), .btn(btn), .sw(sw),
    .x(x), .xv(xv), .hist(hist), .bitcnt(bitcnt)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // Strobe monitor: counts pulses and flags any two-cycle xv.
  always @(negedge clki) begin
    if (xv === 1'b1) begin
      xv_count++;
      n_checks++;
      if (xv_prev === 1'b1) begin
        n_fail++;
        $display("FAIL xv_single_cycle: got xv high two cycles expected one");
      end
    end
    xv_prev = xv;
  end

  typedef struct {
    logic       sw;
    logic       exp_x;
    logic [7:0] exp_hist;
    logic [3:0] exp_bitcnt;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clki);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Press with switch value s; lat is the 0-based edge index (first edge after
  // btn rises is edge 0) after which xv is first seen, -1 if never. The switch
  // is flipped while held to show it is sampled only at the commit edge.
  task automatic press(input logic s, input int hold, output int lat, output int pulses);
    int start;
    start = xv_count;
    sw = s;
    btn = 1'b1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (xv === 1'b1) begin
        lat = i;
        break;
      end
    end
    sw = ~s;
    repeat (hold) tick();
    btn = 1'b0;
    repeat (12) tick();
    pulses = xv_count - start;
  endtask

  initial begin
    int lat;
    int pulses;
    int start;
    int found;

    vecs[0] = '{sw: 1'b1, exp_x: 1'b1, exp_hist: 8'h01, exp_bitcnt: 4'd1};
    vecs[1] = '{sw: 1'b0, exp_x: 1'b0, exp_hist: 8'h02, exp_bitcnt: 4'd2};
    vecs[2] = '{sw: 1'b1, exp_x: 1'b1, exp_hist: 8'h05, exp_bitcnt: 4'd3};
    vecs[3] = '{sw: 1'b1, exp_x: 1'b1, exp_hist: 8'h0B, exp_bitcnt: 4'd4};

    rst = 1'b1;
    btn = 1'b0;
    sw  = 1'b0;
    do_reset();
    check("reset_x", 32'(x), 32'd0);
    check("reset_xv", 32'(xv), 32'd0);
    check("reset_hist", 32'(hist), 32'd0);
    check("reset_bitcnt", 32'(bitcnt), 32'd0);
    check("reset_state", 32'(dut.state), 32'(RELEASED));

    // Bounce rejection
    start = xv_count;
    sw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      btn = (i % 2 == 0);
      tick();
    end
    btn = 1'b0;
    repeat (10) tick();
    check("bounce_pulses", 32'(xv_count - start), 32'd0);
    check("bounce_bitcnt", 32'(bitcnt), 32'd0);
    check("bounce_state", 32'(dut.state), 32'(RELEASED));

    // Clean press, long hold
    press(1'b1, 20, lat, pulses);
    check("clean_latency", 32'(lat), 32'(LAT));
    check("clean_pulses", 32'(pulses), 32'd1);
    check("clean_x", 32'(x), 32'd1);
    check("clean_hist", 32'(hist), 32'h01);
    check("clean_bitcnt", 32'(bitcnt), 32'd1);

    // Sequence entry 1,0,1,1
    do_reset();
    for (int v = 0; v < 4; v++) begin
      press(vecs[v].sw, 3, lat, pulses);
      check("seq_latency", 32'(lat), 32'(LAT));
      check("seq_pulses", 32'(pulses), 32'd1);
      check("seq_x", 32'(x), 32'(vecs[v].exp_x));
      check("seq_hist", 32'(hist), 32'(vecs[v].exp_hist));
      check("seq_bitcnt", 32'(bitcnt), 32'(vecs[v].exp_bitcnt));
    end

    // Release bounce: 2-cycle drop during a hold must not re-commit
    start = xv_count;
    sw = 1'b0;
    btn = 1'b1;
    repeat (LAT + 4) tick();
    btn = 1'b0;
    tick();
    tick();
    btn = 1'b1;
    repeat (6) tick();
    check("relbounce_state", 32'(dut.state), 32'(PRESSED));
    check("relbounce_pulses_held", 32'(xv_count - start), 32'd1);
    btn = 1'b0;
    repeat (12) tick();
    check("relbounce_pulses", 32'(xv_count - start), 32'd1);
    check("relbounce_hist", 32'(hist), 32'h16);
    check("relbounce_bitcnt", 32'(bitcnt), 32'd5);

    // Reset mid-press at cnt==2
    sw = 1'b1;
    btn = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dut.state == PRESS_WAIT && dut.cnt == 2) begin
        found = 1;
        break;
      end
    end
    check("midrst_reached_cnt2", 32'(found), 32'd1);
    rst = 1'b0;
    tick();
    check("midrst_x", 32'(x), 32'd0);
    check("midrst_xv", 32'(xv), 32'd0);
    check("midrst_hist", 32'(hist), 32'd0);
    check("midrst_bitcnt", 32'(bitcnt), 32'd0);
    rst = 1'b1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (xv === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("midrst_latency", 32'(lat), 32'(LAT));
    btn = 1'b0;
    repeat (12) tick();
    check("midrst_x_after", 32'(x), 32'd1);
    check("midrst_bitcnt_after", 32'(bitcnt), 32'd1);

    // Wrap: 17 zero presses
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      press(1'b0, 2, lat, pulses);
      check("wrap_pulses", 32'(pulses), 32'd1);
      check("wrap_bitcnt", 32'(bitcnt), 32'(i % 16));
    end
    check("wrap_hist", 32'(hist), 32'h00);
    check("wrap_x", 32'(x), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_entry.md
Name: switch_entry

Overview:
- Operator-input front end for the lab boards: turns a raw pushbutton and a raw data slide switch into clean serial bits.
- The bits feed the sequence detector (count01) whose result the 7-segment driver shows.
- Each debounced button press commits the current switch value as one bit: registered data plus a one-cycle valid strobe.
- Also keeps an 8-bit history and a 4-bit bit count for LED readout.

Parameters:
- DEB_CYCLES, 500000, clock cycles the synchronized button must stay stable before a press or release is accepted (10 ms at 50 MHz); legal range >= 2.
- HIST_W, 8, width of the bit-history shift register.

Ports:
- clki  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- btn  input  1  raw pushbutton, asynchronous and bouncing; 1 = pressed.
- sw  input  1  raw data switch, asynchronous.
- x  output  1  last committed bit, registered.
- xv  output  1  one-cycle strobe, high for exactly one cycle per accepted press.
- hist  output  HIST_W  last HIST_W committed bits; newest in bit 0.
- bitcnt  output  4  number of committed bits, modulo 16.

Behaviour:
- Reset, sampled when rst==0 at a clki edge: x=0, xv=0, hist=0, bitcnt=0, state=RELEASED, cnt=0, synchronizer flops=0.
- Synchronizers: btn and sw each pass through 2 flops (btn_s, sw_s). Only btn_s and sw_s are used downstream.
- Debounce counter cnt: width clog2(DEB_CYCLES); cleared on every state change.
- FSM, states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - RELEASED: btn_s==1 -> PRESS_WAIT with cnt=0.
  - PRESS_WAIT:
    - btn_s==0 (bounce) -> RELEASED, cnt=0.
    - btn_s==1 and cnt<DEB_CYCLES-1 -> cnt+1.
    - btn_s==1 and cnt==DEB_CYCLES-1 -> PRESSED. Commit on this same edge:
      - x <= sw_s;
      - xv <= 1;
      - hist <= {hist[HIST_W-2:0], sw_s};
      - bitcnt <= bitcnt+1 (wraps 15 -> 0).
  - PRESSED: xv <= 0 on the next edge, unconditionally. btn_s==0 -> RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT, mirrors PRESS_WAIT:
    - btn_s==1 -> PRESSED;
    - otherwise count to DEB_CYCLES-1, then -> RELEASED.
    - No output activity in this state.
- Latency: with btn high and stable before edge 0, xv is high for the single cycle after edge DEB_CYCLES+2.
- sw is sampled only at the commit edge. Switch changes at any other time have no effect.
- xv is never high two cycles in a row. There is exactly one commit per press-release cycle, however long the button is held.
- Reset mid-operation: rst overrides all state in the same edge; a partially counted press is discarded.
  - If btn is still held after reset, it is treated as a new press and commits after the full latency.
- rst low has priority over every other condition.

Decomposition:
- Shared package entry_pkg holds:
  - the state encoding (2-bit, RELEASED=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3);
  - the default DEB_CYCLES constant;
  - the bitcnt width.
- Natural sub-module: sync2, a 2-flop synchronizer with synchronous active-low reset to 0. It is instantiated twice (btn, sw).
- The FSM, counter and datapath stay in switch_entry.

Test Plan (DEB_CYCLES=4, HIST_W=8):
- Clean press: sw=1, btn 0->1 held 20 cycles before edge 0 -> xv high only after edge 6; x=1, hist=8'h01, bitcnt=1. No further xv while held or on release.
- Bounce rejection: btn toggles 1,0,1,0 each cycle for 8 cycles then stays 0 -> xv never asserts; state returns to RELEASED; bitcnt=0.
- Sequence entry: press with sw values 1,0,1,1 (full release between presses) -> four xv pulses; x follows 1,0,1,1; final hist=8'h0B, bitcnt=4.
- Release bounce: during a hold, btn drops for 2 cycles then returns high -> no second xv; state back in PRESSED.
- Wrap: 17 presses, all sw=0 -> bitcnt goes 15 -> 0 -> 1; hist=8'h00.
- Reset mid-press: rst=0 for 1 cycle at cnt==2 while btn held, sw=1 -> all outputs 0 after that edge; xv asserts DEB_CYCLES+2 edges after rst returns high (synchronizers refill from 0); bitcnt=1.
